// File: rtl/regfile_wb.sv
// Two-write / two-read register file for the writeback stage. M port wins same-index
// conflicts, optional same-cycle write-to-read bypass, and a committed-write counter.
module regfile_wb #(
  parameter int              XLEN      = 64,
  parameter int              NREGS     = 15,
  parameter int              SP_IDX    = 4,
  parameter logic [XLEN-1:0] SP_RESET  = 'd32,
  parameter logic [XLEN-1:0] REG_RESET = 'hF,
  parameter int              BYPASS    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [3:0]            dstE,
  input  logic [XLEN-1:0]       valE,
  input  logic [3:0]            dstM,
  input  logic [XLEN-1:0]       valM,
  input  logic [3:0]            srcA,
  input  logic [3:0]            srcB,
  output logic [XLEN-1:0]       valA,
  output logic [XLEN-1:0]       valB,
  output logic [NREGS*XLEN-1:0] reg_dump,
  output logic [15:0]           wr_count
);

  logic [XLEN-1:0] r_regs [NREGS];
  logic [15:0]     r_wr_count;

  logic w_e_act;
  logic w_m_act;
  logic w_e_wr;
  logic w_byp;

  function automatic logic f_valid(input logic [3:0] idx);
    return int'(idx) < NREGS;
  endfunction

  function automatic logic [XLEN-1:0] f_rst_val(input int idx);
    return (idx == SP_IDX) ? SP_RESET : REG_RESET;
  endfunction

  // Invalid indices (including RNONE) read as zero.
  function automatic logic [XLEN-1:0] f_read(input logic [3:0] src);
    logic [XLEN-1:0] v;
    v = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (src == 4'(i)) v = r_regs[i];
    end
    return v;
  endfunction

  assign w_e_act = wr_en && rst_n && f_valid(dstE);
  assign w_m_act = wr_en && rst_n && f_valid(dstM);
  // E is dropped when M targets the same register (popq %rsp).
  assign w_e_wr  = w_e_act && !(w_m_act && (dstE == dstM));
  assign w_byp   = (BYPASS != 0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= f_rst_val(i);
      r_wr_count <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (w_m_act && (dstM == 4'(i)))
          r_regs[i] <= valM;
        else if (w_e_wr && (dstE == 4'(i)))
          r_regs[i] <= valE;
      end
      r_wr_count <= r_wr_count + 16'(w_e_wr) + 16'(w_m_act);
    end
  end

  always_comb begin
    valA = f_read(srcA);
    valB = f_read(srcB);
    if (w_byp) begin
      if (w_m_act && (srcA == dstM))      valA = valM;
      else if (w_e_act && (srcA == dstE)) valA = valE;
      if (w_m_act && (srcB == dstM))      valB = valM;
      else if (w_e_act && (srcB == dstE)) valB = valE;
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_dump
    assign reg_dump[g*XLEN +: XLEN] = r_regs[g];
  end

  assign wr_count = r_wr_count;

endmodule

// File: tb/tb_regfile_wb.sv
// Directed bench for regfile_wb: default bypassing instance, a non-bypassing instance
// sharing its stimulus, and a narrow 8-register 32-bit instance.
module tb_regfile_wb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, wr_en, wr_en2;
  logic [3:0]  dstE, dstM, srcA, srcB;
  logic [3:0]  dstE2, dstM2, srcA2, srcB2;
  logic [63:0] valE, valM, valA0, valB0, valA1, valB1;
  logic [31:0] valE2, valM2, valA2, valB2;
  logic [15*64-1:0] dump0, dump1;
  logic [8*32-1:0]  dump2;
  logic [15:0] cnt0, cnt1, cnt2;

  logic [63:0] m [15];
  int n_tests = 0;
  int n_fail  = 0;

  regfile_wb u0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .dstE(dstE), .valE(valE),
    .dstM(dstM), .valM(valM), .srcA(srcA), .srcB(srcB), .valA(valA0),
    .valB(valB0), .reg_dump(dump0), .wr_count(cnt0));

  regfile_wb #(.BYPASS(0)) u1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .dstE(dstE), .valE(valE),
    .dstM(dstM), .valM(valM), .srcA(srcA), .srcB(srcB), .valA(valA1),
    .valB(valB1), .reg_dump(dump1), .wr_count(cnt1));

  regfile_wb #(.XLEN(32), .NREGS(8), .SP_RESET(32'd32), .REG_RESET(32'hF)) u2 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en2), .dstE(dstE2), .valE(valE2),
    .dstM(dstM2), .valM(valM2), .srcA(srcA2), .srcB(srcB2), .valA(valA2),
    .valB(valB2), .reg_dump(dump2), .wr_count(cnt2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 15; i++) m[i] = (i == 4) ? 64'd32 : 64'hF;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_en = 1'b1; dstE = 4'd0; valE = 64'd5; dstM = 4'hF; valM = '0;
    srcA = 4'd0; srcB = 4'd4;
    wr_en2 = 1'b0; dstE2 = 4'hF; dstM2 = 4'hF; valE2 = '0; valM2 = '0; srcA2 = 4'hF; srcB2 = 4'hF;
    tick(); tick();
    model_reset();
    for (int i = 0; i < 15; i++) begin
      n_tests++;
      if (dump0[i*64 +: 64] !== m[i]) begin
        n_fail++; $display("FAIL reset_reg%0d got=%h exp=%h", i, dump0[i*64 +: 64], m[i]);
      end
    end
    n_tests++;
    if (cnt0 !== 16'd0) begin n_fail++; $display("FAIL reset_cnt0 got=%h exp=0", cnt0); end
    n_tests++;
    if (cnt1 !== 16'd0) begin n_fail++; $display("FAIL reset_cnt1 got=%h exp=0", cnt1); end
    n_tests++;
    if (valA0 !== 64'hF) begin n_fail++; $display("FAIL reset_nobypass_valA got=%h exp=f", valA0); end
    n_tests++;
    if (valB0 !== 64'd32) begin n_fail++; $display("FAIL reset_valB_sp got=%h exp=20", valB0); end
    rst_n = 1'b1; wr_en = 1'b0;
  endtask

  task automatic test_dual_write();
    dstE = 4'd1; valE = 64'hAA; dstM = 4'd2; valM = 64'hBB; wr_en = 1'b1;
    tick();
    wr_en = 1'b0; m[1] = 64'hAA; m[2] = 64'hBB;
    n_tests++;
    if (dump0[1*64 +: 64] !== 64'hAA) begin n_fail++; $display("FAIL dual_reg1 got=%h exp=aa", dump0[1*64 +: 64]); end
    n_tests++;
    if (dump0[2*64 +: 64] !== 64'hBB) begin n_fail++; $display("FAIL dual_reg2 got=%h exp=bb", dump0[2*64 +: 64]); end
    n_tests++;
    if (dump1[1*64 +: 64] !== 64'hAA) begin n_fail++; $display("FAIL dual_u1_reg1 got=%h exp=aa", dump1[1*64 +: 64]); end
    n_tests++;
    if (cnt0 !== 16'd2) begin n_fail++; $display("FAIL dual_cnt got=%0d exp=2", cnt0); end
    n_tests++;
    if (cnt1 !== 16'd2) begin n_fail++; $display("FAIL dual_cnt_u1 got=%0d exp=2", cnt1); end
  endtask

  task automatic test_conflict();
    dstE = 4'd4; valE = 64'h40; dstM = 4'd4; valM = 64'h99; srcA = 4'd4; wr_en = 1'b1;
    #1;
    n_tests++;
    if (valA0 !== 64'h99) begin n_fail++; $display("FAIL conflict_bypass got=%h exp=99", valA0); end
    n_tests++;
    if (valA1 !== 64'd32) begin n_fail++; $display("FAIL conflict_nobypass got=%h exp=20", valA1); end
    tick();
    wr_en = 1'b0; m[4] = 64'h99;
    n_tests++;
    if (dump0[4*64 +: 64] !== 64'h99) begin n_fail++; $display("FAIL conflict_reg4 got=%h exp=99", dump0[4*64 +: 64]); end
    n_tests++;
    if (cnt0 !== 16'd3) begin n_fail++; $display("FAIL conflict_cnt got=%0d exp=3", cnt0); end
  endtask

  task automatic test_bypass();
    dstE = 4'hF; valE = 64'h0; dstM = 4'd3; valM = 64'd7; srcA = 4'd3; srcB = 4'hF; wr_en = 1'b1;
    #1;
    n_tests++;
    if (valA0 !== 64'd7) begin n_fail++; $display("FAIL bypM_valA got=%h exp=7", valA0); end
    n_tests++;
    if (valB0 !== 64'd0) begin n_fail++; $display("FAIL bypM_valB_rnone got=%h exp=0", valB0); end
    n_tests++;
    if (valA1 !== 64'hF) begin n_fail++; $display("FAIL nobyp_old got=%h exp=f", valA1); end
    n_tests++;
    if (valB1 !== 64'd0) begin n_fail++; $display("FAIL nobyp_valB_rnone got=%h exp=0", valB1); end
    tick();
    wr_en = 1'b0; m[3] = 64'd7;
    #1;
    n_tests++;
    if (valA1 !== 64'd7) begin n_fail++; $display("FAIL nobyp_next got=%h exp=7", valA1); end
    dstE = 4'd5; valE = 64'h55; dstM = 4'hF; srcB = 4'd5; wr_en = 1'b1;
    #1;
    n_tests++;
    if (valB0 !== 64'h55) begin n_fail++; $display("FAIL bypE_valB got=%h exp=55", valB0); end
    n_tests++;
    if (valB1 !== 64'hF) begin n_fail++; $display("FAIL nobypE_valB got=%h exp=f", valB1); end
    tick();
    wr_en = 1'b0; m[5] = 64'h55;
    n_tests++;
    if (cnt0 !== 16'd5) begin n_fail++; $display("FAIL bypass_cnt got=%0d exp=5", cnt0); end
  endtask

  task automatic test_gating();
    wr_en = 1'b0; dstE = 4'd5; valE = 64'h123; dstM = 4'd6; valM = 64'h456;
    tick();
    n_tests++;
    if (dump0[5*64 +: 64] !== 64'h55) begin n_fail++; $display("FAIL gate_reg5 got=%h exp=55", dump0[5*64 +: 64]); end
    n_tests++;
    if (cnt0 !== 16'd5) begin n_fail++; $display("FAIL gate_cnt got=%0d exp=5", cnt0); end
    wr_en = 1'b1; dstE = 4'hF; valE = 64'hEE; dstM = 4'hF; valM = 64'hEF;
    tick();
    wr_en = 1'b0;
    for (int i = 0; i < 15; i++) begin
      n_tests++;
      if (dump0[i*64 +: 64] !== m[i]) begin
        n_fail++; $display("FAIL rnone_reg%0d got=%h exp=%h", i, dump0[i*64 +: 64], m[i]);
      end
    end
    n_tests++;
    if (cnt0 !== 16'd5) begin n_fail++; $display("FAIL rnone_cnt got=%0d exp=5", cnt0); end
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0; wr_en = 1'b1; dstE = 4'd1; valE = 64'h77; dstM = 4'd2; valM = 64'h78;
    tick();
    rst_n = 1'b1; wr_en = 1'b0; model_reset();
    n_tests++;
    if (dump0[1*64 +: 64] !== 64'hF) begin n_fail++; $display("FAIL rstmid_reg1 got=%h exp=f", dump0[1*64 +: 64]); end
    n_tests++;
    if (dump0[2*64 +: 64] !== 64'hF) begin n_fail++; $display("FAIL rstmid_reg2 got=%h exp=f", dump0[2*64 +: 64]); end
    n_tests++;
    if (dump0[4*64 +: 64] !== 64'd32) begin n_fail++; $display("FAIL rstmid_sp got=%h exp=20", dump0[4*64 +: 64]); end
    n_tests++;
    if (cnt0 !== 16'd0) begin n_fail++; $display("FAIL rstmid_cnt got=%0d exp=0", cnt0); end
  endtask

  task automatic test_param();
    wr_en2 = 1'b1; dstE2 = 4'd9; valE2 = 32'hDEAD; dstM2 = 4'hF; srcA2 = 4'd9; srcB2 = 4'd7;
    #1;
    n_tests++;
    if (valA2 !== 32'd0) begin n_fail++; $display("FAIL p_srcA9 got=%h exp=0", valA2); end
    tick();
    n_tests++;
    if (cnt2 !== 16'd0) begin n_fail++; $display("FAIL p_dst9_cnt got=%0d exp=0", cnt2); end
    n_tests++;
    if (dump2[4*32 +: 32] !== 32'd32) begin n_fail++; $display("FAIL p_sp got=%h exp=20", dump2[4*32 +: 32]); end
    n_tests++;
    if (dump2[1*32 +: 32] !== 32'hF) begin n_fail++; $display("FAIL p_reg1 got=%h exp=f", dump2[1*32 +: 32]); end
    dstE2 = 4'd7; valE2 = 32'h1234_5678;
    #1;
    n_tests++;
    if (valB2 !== 32'h1234_5678) begin n_fail++; $display("FAIL p_byp7 got=%h exp=12345678", valB2); end
    tick();
    wr_en2 = 1'b0;
    n_tests++;
    if (dump2[7*32 +: 32] !== 32'h1234_5678) begin n_fail++; $display("FAIL p_reg7 got=%h exp=12345678", dump2[7*32 +: 32]); end
    n_tests++;
    if (cnt2 !== 16'd1) begin n_fail++; $display("FAIL p_cnt got=%0d exp=1", cnt2); end
  endtask

  task automatic test_wrap();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    wr_en2 = 1'b1; dstE2 = 4'd0; dstM2 = 4'd1;
    for (int i = 0; i < 32767; i++) begin
      valE2 = 32'(i); valM2 = 32'(i + 1);
      tick();
    end
    dstM2 = 4'hF;
    tick();
    n_tests++;
    if (cnt2 !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_pre got=%h exp=ffff", cnt2); end
    dstE2 = 4'd2; valE2 = 32'hA2; dstM2 = 4'd3; valM2 = 32'hA3;
    tick();
    wr_en2 = 1'b0;
    n_tests++;
    if (cnt2 !== 16'h0001) begin n_fail++; $display("FAIL wrap_post got=%h exp=0001", cnt2); end
    n_tests++;
    if (dump2[3*32 +: 32] !== 32'hA3) begin n_fail++; $display("FAIL wrap_reg3 got=%h exp=a3", dump2[3*32 +: 32]); end
  endtask

  initial begin
    test_reset();
    test_dual_write();
    test_conflict();
    test_bypass();
    test_gating();
    test_reset_mid();
    test_param();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb.md
# regfile_wb

Parametrised two-write/two-read register file, the successor to the SEQ writeback register bank. Decode reads it and writeback writes it in the same cycle. It has independent E and M write ports with a fixed conflict priority, optional write-to-read bypass, and configurable width, register count and reset values. It also exposes a flat register dump and a committed-write counter to the testbench and debug logic.

## Interface
Parameters:
- XLEN, 64, data width of each register.
- NREGS, 15, number of architectural registers; legal range 1..15. Index 4'hF is always RNONE.
- SP_IDX, 4, index of the stack pointer.
- SP_RESET, 64'd32, reset value of register SP_IDX.
- REG_RESET, 64'hF, reset value of every other register.
- BYPASS, 1, 1 forwards same-cycle writes to the read ports; 0 reads the array only.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst_n, input, 1, synchronous, active-low reset.
- wr_en, input, 1, global write enable (stall/bubble gate); 0 suppresses both writes.
- dstE, input, 4, E-port destination index.
- valE, input, XLEN, E-port write data.
- dstM, input, 4, M-port destination index.
- valM, input, XLEN, M-port write data.
- srcA, input, 4, read port A index.
- srcB, input, 4, read port B index.
- valA, output, XLEN, read port A data (combinational).
- valB, output, XLEN, read port B data (combinational).
- reg_dump, output, NREGS*XLEN, register i on bits [i*XLEN +: XLEN] (registered array contents).
- wr_count, output, 16, committed-write counter.

## Operation
- **Index validity:** an index is valid when it is below NREGS. 4'hF and any index of NREGS or above are invalid.
- **Write ports:** a port is active when wr_en=1, rst_n=1 and its index is valid. An active port writes its value into reg[dst] on the rising edge.
- **Write conflict:** when both ports are active and dstE==dstM, valM is written and valE is discarded (popq %rsp semantics).
- **Read ports:** an invalid src index returns 0.
- **Read with BYPASS=1:**
  - If the M port is active and srcX==dstM, valX=valM.
  - Else if the E port is active and srcX==dstE, valX=valE.
  - Else valX=reg[srcX].
- **Read with BYPASS=0:** valX=reg[srcX] always.
- **Read during reset:** bypass is suppressed while rst_n=0. Reads return current array contents.
- **wr_count:**
  - Adds 1 per distinct register written that cycle: 0, 1 or 2. A same-index conflict counts as 1.
  - Wraps modulo 2^16.
  - Writes of a value equal to the existing contents still count.
- **Reset (rst_n=0 at a rising edge):**
  - reg[SP_IDX] <= SP_RESET; all other registers <= REG_RESET.
  - wr_count <= 0.
  - Reset overrides any concurrent write.
- If SP_IDX >= NREGS, SP_RESET is unused and every register resets to REG_RESET.

## Timing
- **Write latency:** 1 cycle. Data presented in cycle n appears in reg_dump after rising edge n.
- **Read latency:** 0 cycles (combinational from src/dst/val/wr_en). With BYPASS=1 a read in cycle n sees the cycle-n write.
- **Reset values:**
  - Outputs settle to reset values one edge after rst_n is sampled low.
  - reg_dump shows SP_RESET at SP_IDX and REG_RESET elsewhere; wr_count=0.
  - valA/valB reflect the reset array.
- **Reset mid-operation:** a write presented in the same cycle as rst_n=0 is lost and not counted.
- **Simultaneous read/write of the same register, BYPASS=0:** the read returns the old value; the new value is visible the next cycle.
- **Counter wrap:** wr_count=16'hFFFF with 2 writes -> 16'h0001.
- No handshake, no backpressure, no X propagation from invalid indices.

## Test plan
- **Reset:** hold rst_n=0 for 2 cycles with wr_en=1, dstE=0, valE=5 -> reg_dump has reg4=32 and all others 15; wr_count=0; no write occurred.
- **Dual write, distinct indices:** dstE=1/valE=0xAA, dstM=2/valM=0xBB, wr_en=1 -> next cycle reg1=0xAA, reg2=0xBB, wr_count=2.
- **Conflict:** dstE=dstM=4, valE=0x40, valM=0x99 -> reg4=0x99, wr_count increments by 1.
- **Bypass:** BYPASS=1, dstM=3/valM=7, srcA=3, srcB=0xF -> valA=7 in the same cycle, valB=0.
  - Repeat with BYPASS=0 -> valA=15 (old value) that cycle, then 7 next cycle.
- **Gating and invalid index:** wr_en=0 with dstE=5 -> no change and no count. wr_en=1 with dstE=0xF -> no change and no count.
- **Parametrisation:** NREGS=8, XLEN=32, dstE=9 -> ignored; srcA=9 -> 0.
  - Preload wr_count to 0xFFFF via 65535 writes, then one dual write -> 0x0001.
